// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO.
// 33-edge sequence per mul/div; MTHI/MTLO complete in one edge.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_md;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_dtrial;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept = start & (r_state == S_IDLE);
  assign w_md     = w_accept & ~op[2];
  assign w_mthi   = w_accept & (op == OP_MTHI);
  assign w_mtlo   = w_accept & (op == OP_MTLO);

  // op[0]=0 selects the signed flavour (MULT/DIV)
  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Multiply: acc = {partial, multiplier}, add then shift right
  assign w_addend  = r_acc[0] ? r_m : '0;
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend}, restoring shift-subtract
  assign w_dtrial  = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
  assign w_div_nxt = w_dtrial[WIDTH]
                   ? {r_acc[2*WIDTH-2:0], 1'b0}
                   : {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Remainder correction also restores the raw dividend on divide-by-zero
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                          : r_acc[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_md) w_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_mthi) begin
        r_hi   <= a;
        r_done <= 1'b1;
      end
      if (w_mtlo) begin
        r_lo   <= a;
        r_done <= 1'b1;
      end
      if (w_md) begin
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_m     <= w_b_mag;
        r_div   <= op[1];
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dz    <= op[1] & (b == '0);
        r_cnt   <= 32'(WIDTH - 1);
      end
      if (r_state == S_RUN) begin
        r_acc <= r_div ? w_div_nxt : w_mul_nxt;
        if (r_cnt != '0) r_cnt <= r_cnt - 32'd1;
      end
      if (r_state == S_FIN) begin
        r_done <= 1'b1;
        if (r_div) begin
          r_lo <= r_dz ? '1 : w_quo;
          r_hi <= w_rem;
        end else begin
          {r_hi, r_lo} <= w_prod;
        end
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: transaction-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int errors  = 0;
  bit cmp_en  = 1'b0;

  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  int          m_cnt  = 0;
  bit          m_done = 1'b0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Architectural results straight from the arithmetic definitions
  task automatic ref_op(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        output logic [31:0] h,
                        output logic [31:0] l);
    longint lx, ly;
    logic [63:0] p;
    int ix, iy;
    h = '0;
    l = '0;
    case (o)
      3'b000: begin
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        p = 64'(lx * ly);
        {h, l} = p;
      end
      3'b001: begin
        p = {32'b0, x} * {32'b0, y};
        {h, l} = p;
      end
      3'b010: begin
        if (y == 0) begin
          h = x;
          l = '1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = '0;
          l = 32'h8000_0000;
        end else begin
          ix = $signed(x);
          iy = $signed(y);
          l = 32'(ix / iy);
          h = 32'(ix % iy);
        end
      end
      3'b011: begin
        if (y == 0) begin
          h = x;
          l = '1;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Reference model: result lands 33 edges after acceptance
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   = '0;
      m_lo   = '0;
      m_cnt  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else if (start) begin
        case (op)
          3'b100: begin m_hi = a; m_done = 1'b1; end
          3'b101: begin m_lo = a; m_done = 1'b1; end
          3'b000, 3'b001, 3'b010, 3'b011: begin
            ref_op(op, a, b, p_hi, p_lo);
            m_cnt = 33;
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(busy), 32'(m_cnt > 0));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle(output int n);
    bit ok;
    ok = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after 40 cycles", busy);
    end
  endtask

  task automatic run_md(input string name,
                        input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    int n;
    issue(o, x, y);
    wait_idle(n);
    check({name, "_busycyc"}, 32'(n), 32'd33);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n;
    tbl[0] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
    tbl[1] = '{3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'b011, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF};
    tbl[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    tbl[5] = '{3'b010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    tbl[6] = '{3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30};
    tbl[7] = '{3'b011, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999};
    tbl[8] = '{3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};

    reset = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    foreach (tbl[i]) begin
      run_md($sformatf("vec%0d", i), tbl[i].o, tbl[i].x,
             tbl[i].y, tbl[i].eh, tbl[i].el);
      @(negedge clk);
      check($sformatf("vec%0d_done_once", i), 32'(done), 32'd0);
    end

    // Reserved op is ignored
    issue(3'b110, 32'h1111_1111, 32'h2);
    check("rsv_busy", 32'(busy), 32'd0);
    check("rsv_done", 32'(done), 32'd0);

    // Back-to-back MTHI / MTLO
    @(negedge clk);
    start = 1'b1;
    op = 3'b100;
    a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_done", 32'(done), 32'd1);
    check("mthi_busy", 32'(busy), 32'd0);
    op = 3'b101;
    a = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h0BAD_F00D);
    check("mtlo_hi", hi, 32'hDEAD_BEEF);
    check("mtlo_done", 32'(done), 32'd1);
    run_md("divu100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

    // MTLO while busy must be dropped
    issue(3'b011, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    start = 1'b1;
    op = 3'b101;
    a = 32'h5;
    @(negedge clk);
    start = 1'b0;
    check("busy_mtlo_lo", lo, 32'd14);
    wait_idle(n);
    check("busy_mtlo_fin_lo", lo, 32'd14);
    check("busy_mtlo_fin_hi", hi, 32'd2);

    // Reset mid-operation abandons the op
    issue(3'b001, 32'd6, 32'd7);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (25) @(negedge clk);
    check("midrst_nodone", 32'(done), 32'd0);
    run_md("multu6_7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
